// File: rtl/sqrt_inv.sv
// Inverse integer square root: rebuilds x = y*y + r with a 16-step shift-add
// multiplier, then flags remainders that are larger than any valid remainder for y.
module sqrt_inv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld_in,
  input  logic [15:0] y,
  input  logic [16:0] r,
  output logic        vld_out,
  output logic [31:0] x,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ADD  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] y_q;
  logic [16:0] r_q;
  logic [31:0] acc;
  logic [3:0]  cnt;
  logic        y_bit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (vld_in) state_next = CALC;
      CALC:    if (cnt == 4'd15) state_next = ADD;
      ADD:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  assign busy  = (state != IDLE);
  // Multiplier bits are consumed MSB-first, so step cnt uses bit 15-cnt.
  assign y_bit = y_q[4'd15 - cnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      r_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      x       <= '0;
      err     <= 1'b0;
      vld_out <= 1'b0;
    end else begin
      vld_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (vld_in) begin
            y_q <= y;
            r_q <= r;
            acc <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          acc <= {acc[30:0], 1'b0} + (y_bit ? {16'b0, y_q} : 32'b0);
          cnt <= cnt + 4'd1;
        end
        ADD: begin
          x       <= acc + {15'b0, r_q};
          // 18-bit compare: 2*y needs 17 bits and r is zero-extended to match.
          err     <= ({1'b0, r_q} > {1'b0, y_q, 1'b0});
          vld_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_inv.sv
// Directed bench for sqrt_inv: stimulus pushes expected results into a queue,
// and a monitor pops and compares them whenever vld_out is seen.
module tb_sqrt_inv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld_in;
  logic [15:0] y;
  logic [16:0] r;
  logic        vld_out;
  logic [31:0] x;
  logic        busy;
  logic        err;

  typedef struct {
    logic [31:0] x;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  sqrt_inv dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_in  (vld_in),
    .y       (y),
    .r       (r),
    .vld_out (vld_out),
    .x       (x),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any result strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (vld_out === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_vld_out", {31'b0, vld_out}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_x", x, e.x);
        check("result_err", {31'b0, err}, {31'b0, e.err});
        check("busy_low_at_vld", {31'b0, busy}, 32'd0);
      end
    end
  end

  // Issue one request accepted at the next rising edge (E0); returns #1 after E0.
  task automatic start(input logic [15:0] yy, input logic [16:0] rr, input bit push,
                       input logic [31:0] ex, input bit ee);
    exp_t e;
    @(negedge clk);
    y      = yy;
    r      = rr;
    vld_in = 1'b1;
    if (push) begin
      e.x   = ex;
      e.err = ee;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    vld_in = 1'b0;
    y      = 16'($urandom);
    r      = 17'($urandom);
    check("busy_after_accept", {31'b0, busy}, 32'd1);
  endtask

  // Waits for vld_out, counting edges since E0; the result must land at E17.
  task automatic wait_result(input int elapsed);
    int lat;
    bit seen;
    lat  = elapsed;
    seen = 1'b0;
    while (lat < 40 && !seen) begin
      @(posedge clk);
      lat++;
      #1;
      seen = vld_out;
    end
    check("latency", lat, 32'd17);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    vld_in = 1'b0;
    y      = '0;
    r      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_x", x, 32'd0);
    check("reset_err", {31'b0, err}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_vld_out", {31'b0, vld_out}, 32'd0);

    // Release reset so the very next edge carries the first request.
    @(posedge clk);
    #2 rst_n = 1'b1;

    start(16'd16, 17'd0, 1'b1, 32'd256, 1'b0);
    wait_result(0);
    @(posedge clk);
    #1;
    check("vld_pulse_width", {31'b0, vld_out}, 32'd0);
    check("x_hold_256", x, 32'd256);

    // A second strobe at E5 must be ignored.
    start(16'd15, 17'd30, 1'b1, 32'd255, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    y      = 16'd1;
    r      = 17'd0;
    vld_in = 1'b1;
    @(posedge clk);
    #1;
    vld_in = 1'b0;
    check("busy_ignore", {31'b0, busy}, 32'd1);
    wait_result(5);
    @(posedge clk);
    #1;
    check("x_hold_255", x, 32'd255);
    check("no_second_result", {31'b0, vld_out}, 32'd0);

    start(16'd46340, 17'd88048, 1'b1, 32'h8000_0000, 1'b0);
    wait_result(0);
    start(16'd65535, 17'd131070, 1'b1, 32'hFFFF_FFFF, 1'b0);
    wait_result(0);
    start(16'd65535, 17'd131071, 1'b1, 32'h0000_0000, 1'b1);
    wait_result(0);
    start(16'd0, 17'd5, 1'b1, 32'd5, 1'b1);
    wait_result(0);
    start(16'd0, 17'd0, 1'b1, 32'd0, 1'b0);
    wait_result(0);

    // Back-to-back: second request lands on E18, the edge right after the result.
    start(16'd3, 17'd0, 1'b1, 32'd9, 1'b0);
    wait_result(0);
    check("busy_gap", {31'b0, busy}, 32'd0);
    start(16'd4, 17'd8, 1'b1, 32'd24, 1'b0);
    wait_result(0);

    // Abort mid-operation: no result may follow for the aborted request.
    start(16'd100, 17'd7, 1'b0, 32'd0, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_x", x, 32'd0);
    check("abort_err", {31'b0, err}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_vld_out", {31'b0, vld_out}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    start(16'd2, 17'd1, 1'b1, 32'd5, 1'b0);
    wait_result(0);

    repeat (20) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
